// File: rtl/lcd_char_feeder.sv
// lcd_char_feeder: buffers ASCII bytes from an upstream source in a small FIFO and
// feeds them to a 4-bit LCD controller. Each byte goes out as two nibbles, high
// nibble first. Every nibble is a one-cycle write pulse followed by an
// acknowledge wait.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   iReset_n      synchronous active-low reset
//   iChar         byte from upstream, accepted when iChar_valid & oChar_ready
//   iChar_valid   iChar is valid this cycle
//   oChar_ready   FIFO not full
//   iLCD_response controller ready/ack (high = idle, waiting for data)
//   oLCD_data     nibble to the controller
//   oLCD_writeEN  one-cycle write request
//   oBusy         a byte is in flight or the FIFO holds data
//   oError        sticky acknowledge-timeout flag
//   oCount        FIFO occupancy
module lcd_char_feeder #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          iReset_n,
  input  logic [7:0]                    iChar,
  input  logic                          iChar_valid,
  output logic                          oChar_ready,
  input  logic                          iLCD_response,
  output logic [3:0]                    oLCD_data,
  output logic                          oLCD_writeEN,
  output logic                          oBusy,
  output logic                          oError,
  output logic [$clog2(FIFO_DEPTH):0]   oCount
);

  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned TmoW       = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned TmoLastInt = ACK_TIMEOUT - 1;
  localparam logic [PtrW:0]   FullCount = FIFO_DEPTH[PtrW:0];
  localparam logic [TmoW-1:0] TmoLast   = TmoLastInt[TmoW-1:0];

  typedef enum logic [2:0] {
    StWaitInit,
    StIdle,
    StSendHi,
    StAckHi,
    StSendLo,
    StAckLo
  } state_e;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic [7:0]      hold_q, hold_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  state_e          state_q, state_d;
  logic [3:0]      data_q, data_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            push, pop;

  // Ready is a registered copy of "not full", so it never depends on a same-cycle pop.
  assign push = iChar_valid & ready_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    we_d    = 1'b0;
    err_d   = err_q;
    pop     = 1'b0;

    unique case (state_q)
      StWaitInit: begin
        if (iLCD_response) state_d = StIdle;
      end
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          hold_d  = mem_q[rd_ptr_q];
          state_d = StSendHi;
        end
      end
      StSendHi: begin
        if (iLCD_response) begin
          data_d  = hold_q[7:4];
          we_d    = 1'b1;
          tmo_d   = '0;
          state_d = StAckHi;
        end
      end
      StAckHi: begin
        if (!iLCD_response) begin
          state_d = StSendLo;
        end else if (tmo_q == TmoLast) begin
          // Controller never acknowledged: flag it and drop the byte.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StSendLo: begin
        if (iLCD_response) begin
          data_d  = hold_q[3:0];
          we_d    = 1'b1;
          tmo_d   = '0;
          state_d = StAckLo;
        end
      end
      StAckLo: begin
        if (!iLCD_response) begin
          state_d = StIdle;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = StWaitInit;
    endcase

    // The data bus is parked at zero whenever no byte is in flight.
    if (state_d == StIdle || state_d == StWaitInit) data_d = '0;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FullCount);
    busy_d  = (state_d != StIdle && state_d != StWaitInit) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!iReset_n) begin
      state_q  <= StWaitInit;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
      tmo_q    <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
      tmo_q    <= tmo_d;
      data_q   <= data_d;
      we_q     <= we_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= iChar;
  end

  assign oChar_ready  = ready_q;
  assign oLCD_data    = data_q;
  assign oLCD_writeEN = we_q;
  assign oBusy        = busy_q;
  assign oError       = err_q;
  assign oCount       = count_q;

endmodule

// File: tb/tb_lcd_char_feeder.sv
// Directed bench for lcd_char_feeder. Expected nibbles are queued when a byte is
// accepted and compared whenever the DUT pulses oLCD_writeEN. A small controller
// model drops the response for three cycles after every write pulse.
module tb_lcd_char_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ch;
  logic       ch_valid;
  logic       ch_ready;
  logic       resp;
  logic [3:0] lcd_data;
  logic       lcd_we;
  logic       busy;
  logic       err;
  logic [3:0] count;

  logic ack_en;
  logic resp_manual;
  logic resp_model = 1'b1;
  int   low_cnt = 0;

  int n_cmp   = 0;
  int n_err   = 0;
  int n_pulse = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  assign resp = ack_en ? resp_model : resp_manual;

  lcd_char_feeder #(
    .FIFO_DEPTH (8),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .iReset_n     (rst_n),
    .iChar        (ch),
    .iChar_valid  (ch_valid),
    .oChar_ready  (ch_ready),
    .iLCD_response(resp),
    .oLCD_data    (lcd_data),
    .oLCD_writeEN (lcd_we),
    .oBusy        (busy),
    .oError       (err),
    .oCount       (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model: acknowledge every pulse by dropping the response for 3 cycles.
  always @(negedge clk) begin
    if (!ack_en) begin
      resp_model = 1'b1;
      low_cnt    = 0;
    end else if (lcd_we === 1'b1) begin
      resp_model = 1'b0;
      low_cnt    = 3;
    end else if (low_cnt > 0) begin
      low_cnt--;
      if (low_cnt == 0) resp_model = 1'b1;
    end
  end

  // Scoreboard: every write pulse must carry the next expected nibble.
  always @(negedge clk) begin
    if (lcd_we === 1'b1) begin
      n_pulse++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_pulse: observed data %0h expected no pulse", lcd_data);
        end
      end else begin
        check("nibble", 32'(lcd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Called at a falling edge; presents the byte for one cycle.
  task automatic try_push(input logic [7:0] b, output logic acc);
    ch       = b;
    ch_valid = 1'b1;
    acc      = ch_ready;
    if (acc) begin
      exp_q.push_back(b[7:4]);
      exp_q.push_back(b[3:0]);
    end
    @(negedge clk);
    ch_valid = 1'b0;
  endtask

  // Called at a falling edge; holds reset across one rising edge.
  task automatic do_reset(input logic ack, input logic manual);
    rst_n       = 1'b0;
    ch_valid    = 1'b0;
    ack_en      = ack;
    resp_manual = manual;
    @(negedge clk);
    check("rst_we",    32'(lcd_we),   32'd0);
    check("rst_data",  32'(lcd_data), 32'd0);
    check("rst_err",   32'(err),      32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_ready", 32'(ch_ready), 32'd0);
    check("rst_count", 32'(count),    32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(ch_ready), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((busy || lcd_we) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(k < 2000), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   base;
    int   k;
    int   n_acc;
    int   np;
    logic seen;

    rst_n = 1'b0; ch = '0; ch_valid = 1'b0; ack_en = 1'b0; resp_manual = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0x41 with the latency check.
    do_reset(1'b1, 1'b0);
    check("idle_busy", 32'(busy), 32'd0);
    base = n_pulse;
    try_push(8'h41, acc);
    check("t1_accepted", 32'(acc), 32'd1);
    check("lat_c1", 32'(lcd_we), 32'd0);
    @(negedge clk);
    check("lat_c2", 32'(lcd_we), 32'd0);
    @(negedge clk);
    check("lat_c3", 32'(lcd_we), 32'd1);
    check("lat_data", 32'(lcd_data), 32'h4);
    wait_idle("t1_idle");
    check("t1_pulses", 32'(n_pulse - base), 32'd2);
    check("t1_err", 32'(err), 32'd0);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);
    check("t1_data_idle", 32'(lcd_data), 32'd0);

    // Init gating: nothing goes out until the controller reports ready.
    do_reset(1'b0, 1'b0);
    base = n_pulse;
    try_push(8'h48, acc);
    repeat (100) @(negedge clk);
    check("t2_no_pulse", 32'(n_pulse - base), 32'd0);
    check("t2_count", 32'(count), 32'd1);
    ack_en = 1'b1;
    k = 0; seen = 1'b0;
    while (!seen && k < 3) begin
      @(negedge clk);
      k++;
      seen = lcd_we;
    end
    check("t2_pulse_within3", 32'(seen), 32'd1);
    wait_idle("t2_idle");
    check("t2_pulses", 32'(n_pulse - base), 32'd2);

    // Full FIFO: ninth byte rejected, then 16 pulses in order.
    do_reset(1'b0, 1'b0);
    base = n_pulse; n_acc = 0;
    for (int i = 0; i < 9; i++) begin
      try_push(8'(8'h30 + i), acc);
      if (acc) n_acc++;
      if (i == 8) check("t3_ninth_rejected", 32'(acc), 32'd0);
    end
    check("t3_accepted", 32'(n_acc), 32'd8);
    check("t3_count_full", 32'(count), 32'd8);
    check("t3_ready_low", 32'(ch_ready), 32'd0);
    ack_en = 1'b1;
    wait_idle("t3_idle");
    check("t3_pulses", 32'(n_pulse - base), 32'd16);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);
    check("t3_count_empty", 32'(count), 32'd0);

    // Simultaneous push and pop, then 20 more bytes to wrap the pointers.
    do_reset(1'b0, 1'b0);
    base = n_pulse;
    try_push(8'h50, acc);
    ack_en = 1'b1;
    @(negedge clk);
    check("t4_count_before", 32'(count), 32'd1);
    try_push(8'h51, acc);
    check("t4_count_push_pop", 32'(count), 32'd1);
    n_acc = 0; k = 0;
    while (n_acc < 20 && k < 3000) begin
      try_push(8'(8'h60 + n_acc), acc);
      if (acc) n_acc++;
      k++;
    end
    check("t4_streamed", 32'(n_acc), 32'd20);
    wait_idle("t4_idle");
    check("t4_pulses", 32'(n_pulse - base), 32'd44);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // Acknowledge timeout.
    do_reset(1'b0, 1'b1);
    base = n_pulse;
    try_push(8'h55, acc);
    k = 0; seen = 1'b0;
    while (!seen && k < 6) begin
      seen = lcd_we;
      if (!seen) begin
        @(negedge clk);
        k++;
      end
    end
    check("t5_first_pulse", 32'(seen), 32'd1);
    check("t5_err_before", 32'(err), 32'd0);
    k = 0;
    while (!err && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t5_tmo_cycles", 32'(k), 32'd16);
    check("t5_err_set", 32'(err), 32'd1);
    check("t5_back_idle", 32'(busy), 32'd0);
    check("t5_one_pulse", 32'(n_pulse - base), 32'd1);
    check("t5_pending_lo", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    ack_en = 1'b1;
    base = n_pulse;
    try_push(8'h66, acc);
    wait_idle("t5_idle");
    check("t5_next_pulses", 32'(n_pulse - base), 32'd2);
    check("t5_err_sticky", 32'(err), 32'd1);

    // Reset while waiting for the low-nibble acknowledge.
    base = n_pulse;
    try_push(8'h7E, acc);
    np = 0; k = 0;
    while (np < 2 && k < 60) begin
      @(negedge clk);
      k++;
      if (lcd_we) np++;
    end
    check("t6_two_pulses", 32'(np), 32'd2);
    do_reset(1'b1, 1'b0);
    base = n_pulse;
    repeat (30) @(negedge clk);
    check("t6_no_pulse", 32'(n_pulse - base), 32'd0);
    check("t6_count", 32'(count), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_err_cleared", 32'(err), 32'd0);
    try_push(8'h21, acc);
    wait_idle("t6_idle");
    check("t6_new_pulses", 32'(n_pulse - base), 32'd2);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_char_feeder.md
LCD_CHAR_FEEDER -- requirements
Module: lcd_char_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: byte FIFO depth; power of two; pointers are log2(FIFO_DEPTH) bits.
REQ-002 Parameter ACK_TIMEOUT, default 16: maximum cycles spent waiting for the controller to drop iLCD_response after a write pulse.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 iReset_n  input  1  reset; synchronous, active-low.
REQ-005 iChar  input  8  ASCII byte from upstream.
REQ-006 iChar_valid  input  1  iChar is valid this cycle.
REQ-007 oChar_ready  output  1  FIFO can accept a byte (not full).
REQ-008 iLCD_response  input  1  controller ready/ack; high = idle in data-wait.
REQ-009 oLCD_data  output  4  nibble to controller.
REQ-010 oLCD_writeEN  output  1  write request to controller; one-cycle pulse.
REQ-011 oBusy  output  1  a byte is in flight or the FIFO is non-empty.
REQ-012 oError  output  1  sticky ack-timeout flag.
REQ-013 oCount  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 Push occurs when iChar_valid and oChar_ready are both high; oChar_ready = (oCount != FIFO_DEPTH) and does not depend on same-cycle pop.
REQ-015 Read and write pointers wrap modulo FIFO_DEPTH; oCount is +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-016 A push when full is impossible because ready is low; a pop never occurs when oCount = 0.
REQ-017 FSM states: WAIT_INIT, IDLE, SEND_HI, ACK_HI, SEND_LO, ACK_LO; all outputs are registered.
REQ-018 WAIT_INIT: stay until iLCD_response = 1 is sampled (controller init done), then go to IDLE; FIFO pushes are accepted during WAIT_INIT.
REQ-019 IDLE: if oCount > 0, pop the head into an 8-bit hold register and go to SEND_HI; else stay.
REQ-020 SEND_HI: when iLCD_response = 1 is sampled, register oLCD_data = hold[7:4] and oLCD_writeEN = 1 for the next cycle only; go to ACK_HI and clear the timeout counter.
REQ-021 ACK_HI: hold oLCD_data = hold[7:4] with oLCD_writeEN = 0; on iLCD_response = 0 go to SEND_LO.
REQ-022 SEND_LO and ACK_LO behave as SEND_HI and ACK_HI but use hold[3:0]; when ACK_LO sees iLCD_response = 0, go to IDLE.
REQ-023 Timeout in ACK_HI or ACK_LO: if the counter reaches ACK_TIMEOUT with iLCD_response still 1, then set oError, drop the byte, and go to IDLE; oError clears only on reset.
REQ-024 oLCD_data is 0 in WAIT_INIT and IDLE.
REQ-025 oBusy = (state not IDLE and not WAIT_INIT) or (oCount != 0).
REQ-026 Latency: a byte pushed at cycle N into an empty FIFO, with the FSM in IDLE and iLCD_response held high, produces oLCD_writeEN = 1 at cycle N+3.
REQ-027 Nibble order is always high nibble first, then low nibble; exactly two writeEN pulses per byte unless a timeout occurs.

Reset
REQ-028 While iReset_n = 0 at a clock edge: state = WAIT_INIT, pointers = 0, oCount = 0, hold = 0, timeout counter = 0.
REQ-029 During reset: oLCD_data = 0, oLCD_writeEN = 0, oError = 0, oBusy = 0, oChar_ready = 0.
REQ-030 oChar_ready goes high on the first cycle after iReset_n returns high.
REQ-031 Reset mid-transfer aborts the byte in flight, empties the FIFO, and never emits a partial writeEN pulse after reset.

Verification
REQ-032 Single byte: reset, response = 1, push 0x41 -> writeEN pulse with data 0x4; response forced low for 3 cycles then high -> writeEN pulse with data 0x1; oBusy falls afterwards.
REQ-033 Init gating: push 0x48 while response = 0 for 100 cycles -> no writeEN; response rises -> pulse with data 0x4 within 3 cycles.
REQ-034 Full FIFO: push 9 bytes back-to-back while response = 0 -> oCount = 8, oChar_ready = 0, 9th byte rejected; then run the ack model -> exactly 16 pulses, in order.
REQ-035 Simultaneous push and pop: with oCount = 1 in IDLE, push on the pop cycle -> oCount stays 1 and pointers wrap correctly after 20 bytes.
REQ-036 Timeout: response held at 1 after the first pulse -> oError = 1 after 16 cycles, FSM returns to IDLE, next byte is processed normally, oError stays 1.
REQ-037 Reset in ACK_LO: assert iReset_n = 0 for 1 cycle -> all outputs 0, oCount = 0, no further writeEN until a new push.
